// File: rtl/shift_mix_stage.sv
// AES round stage: ShiftRows then MixColumns (skipped on the final round), registered behind valid/ready.
// SKID=1 buffers two beats so in_ready comes straight from a flop; SKID=0 uses one output register.
module shift_mix_stage #(
  parameter bit SKID = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] in_state,
  input  logic         in_last,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] out_state,
  output logic         out_last,
  output logic         out_valid,
  input  logic         out_ready
);

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  logic [127:0] shifted;
  logic [127:0] mixed;
  logic [127:0] result;

  genvar gi;

  // Byte index 4*c + r; row r rotates left by r columns.
  for (gi = 0; gi < 16; gi++) begin : g_shift
    localparam int R = gi % 4;
    localparam int C = gi / 4;
    assign shifted[8*gi +: 8] = in_state[8*(4*((C+R)%4)+R) +: 8];
  end

  for (gi = 0; gi < 4; gi++) begin : g_mix
    logic [7:0] a0, a1, a2, a3;
    assign a0 = shifted[32*gi      +: 8];
    assign a1 = shifted[32*gi + 8  +: 8];
    assign a2 = shifted[32*gi + 16 +: 8];
    assign a3 = shifted[32*gi + 24 +: 8];
    assign mixed[32*gi      +: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
    assign mixed[32*gi + 8  +: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
    assign mixed[32*gi + 16 +: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
    assign mixed[32*gi + 24 +: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
  end

  assign result = in_last ? shifted : mixed;

  logic [127:0] out_state_q, out_state_d;
  logic         out_last_q, out_last_d;
  logic         out_valid_q, out_valid_d;

  assign out_state = out_state_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;

  if (SKID) begin : g_skid
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
    state_t       state_q, state_d;
    logic [127:0] skid_state_q, skid_state_d;
    logic         skid_last_q, skid_last_d;
    logic         in_ready_q, in_ready_d;
    logic         accept, deliver;

    assign in_ready = in_ready_q;
    assign accept   = in_valid & in_ready_q;
    assign deliver  = out_valid_q & out_ready;

    always_comb begin
      state_d      = state_q;
      out_state_d  = out_state_q;
      out_last_d   = out_last_q;
      skid_state_d = skid_state_q;
      skid_last_d  = skid_last_q;
      case (state_q)
        EMPTY: if (accept) begin
          out_state_d = result;
          out_last_d  = in_last;
          state_d     = ONE;
        end
        ONE: begin
          if (accept && !deliver) begin
            skid_state_d = result;
            skid_last_d  = in_last;
            state_d      = TWO;
          end else if (accept && deliver) begin
            out_state_d = result;
            out_last_d  = in_last;
          end else if (deliver) begin
            state_d = EMPTY;
          end
        end
        TWO: if (deliver) begin
          out_state_d = skid_state_q;
          out_last_d  = skid_last_q;
          state_d     = ONE;
        end
        default: state_d = EMPTY;
      endcase
      out_valid_d = (state_d != EMPTY);
      in_ready_d  = (state_d != TWO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q      <= EMPTY;
        out_state_q  <= '0;
        out_last_q   <= 1'b0;
        out_valid_q  <= 1'b0;
        skid_state_q <= '0;
        skid_last_q  <= 1'b0;
        in_ready_q   <= 1'b0;
      end else begin
        state_q      <= state_d;
        out_state_q  <= out_state_d;
        out_last_q   <= out_last_d;
        out_valid_q  <= out_valid_d;
        skid_state_q <= skid_state_d;
        skid_last_q  <= skid_last_d;
        in_ready_q   <= in_ready_d;
      end
    end
  end else begin : g_reg
    // Holds in_ready low through reset and rises on the first edge after release.
    logic ready_en_q;
    logic accept;

    assign in_ready = ready_en_q & (~out_valid_q | out_ready);
    assign accept   = in_valid & in_ready;

    always_comb begin
      out_state_d = out_state_q;
      out_last_d  = out_last_q;
      out_valid_d = out_valid_q;
      if (accept) begin
        out_state_d = result;
        out_last_d  = in_last;
        out_valid_d = 1'b1;
      end else if (out_ready) begin
        out_valid_d = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ready_en_q  <= 1'b0;
        out_state_q <= '0;
        out_last_q  <= 1'b0;
        out_valid_q <= 1'b0;
      end else begin
        ready_en_q  <= 1'b1;
        out_state_q <= out_state_d;
        out_last_q  <= out_last_d;
        out_valid_q <= out_valid_d;
      end
    end
  end

endmodule

// File: tb/tb_shift_mix_stage.sv
// Random and directed checks of shift_mix_stage (SKID=1 and SKID=0) against a GF(2^8) matrix model.
module tb_shift_mix_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [127:0] in_state = '0;
  logic         in_last = 1'b0;
  logic         iv_s = 1'b0, ir_s, ov_s, or_s = 1'b0, ol_s;
  logic         iv_r = 1'b0, ir_r, ov_r, or_r = 1'b0, ol_r;
  logic [127:0] os_s, os_r;

  shift_mix_stage #(.SKID(1'b1)) u_skid (
    .clk(clk), .rst_n(rst_n), .in_state(in_state), .in_last(in_last),
    .in_valid(iv_s), .in_ready(ir_s), .out_state(os_s), .out_last(ol_s),
    .out_valid(ov_s), .out_ready(or_s)
  );

  shift_mix_stage #(.SKID(1'b0)) u_reg (
    .clk(clk), .rst_n(rst_n), .in_state(in_state), .in_last(in_last),
    .in_valid(iv_r), .in_ready(ir_r), .out_state(os_r), .out_last(ol_r),
    .out_valid(ov_r), .out_ready(or_r)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Generic GF(2^8) multiply by shift-and-add, reduced modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input int k);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (k[i]) p = p ^ (16'(a) << i);
    for (int b = 14; b >= 8; b--) if (p[b]) p = p ^ (16'h011B << (b - 8));
    return p[7:0];
  endfunction

  function automatic logic [128:0] ref_round(input logic [127:0] s, input logic last);
    logic [7:0] m [4][4];
    logic [7:0] sh [4][4];
    logic [7:0] acc;
    logic [127:0] o;
    int coef [4][4];
    coef = '{'{2, 3, 1, 1}, '{1, 2, 3, 1}, '{1, 1, 2, 3}, '{3, 1, 1, 2}};
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) m[r][c] = s[8*(4*c+r) +: 8];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) sh[r][c] = m[r][(c+r)%4];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        if (last) acc = sh[r][c];
        else begin
          acc = 8'h00;
          for (int k = 0; k < 4; k++) acc = acc ^ gmul(sh[k][c], coef[r][k]);
        end
        o[8*(4*c+r) +: 8] = acc;
      end
    return {last, o};
  endfunction

  logic [128:0] q_s[$];
  logic [128:0] q_r[$];
  logic [128:0] exp_s, exp_r;
  int del_s = 0, del_r = 0;
  logic hold_s = 1'b0, hold_r = 1'b0;
  logic [127:0] held_s, held_r;

  always @(negedge clk) begin
    if (rst_n) begin
      if (hold_s && ov_s) check_eq("skid_stable", os_s, held_s);
      if (ov_s && or_s) begin
        if (q_s.size() == 0) check_eq("skid_extra_beat", 128'(ov_s), 128'd0);
        else begin
          exp_s = q_s.pop_front();
          check_eq("skid_state", os_s, exp_s[127:0]);
          check_eq("skid_last", 128'(ol_s), 128'(exp_s[128]));
          del_s++;
          $display("beat skid #%0d last=%0d state=%h", del_s, ol_s, os_s);
        end
      end
      hold_s = ov_s && !or_s;
      held_s = os_s;
      if (iv_s && ir_s) q_s.push_back(ref_round(in_state, in_last));

      if (hold_r && ov_r) check_eq("reg_stable", os_r, held_r);
      if (ov_r && or_r) begin
        if (q_r.size() == 0) check_eq("reg_extra_beat", 128'(ov_r), 128'd0);
        else begin
          exp_r = q_r.pop_front();
          check_eq("reg_state", os_r, exp_r[127:0]);
          check_eq("reg_last", 128'(ol_r), 128'(exp_r[128]));
          del_r++;
          $display("beat reg  #%0d last=%0d state=%h", del_r, ol_r, os_r);
        end
      end
      hold_r = ov_r && !or_r;
      held_r = os_r;
      if (iv_r && ir_r) q_r.push_back(ref_round(in_state, in_last));
    end
  end

  task automatic push_s(input logic [127:0] st, input logic l);
    int n;
    n = 0;
    in_state = st;
    in_last  = l;
    iv_s     = 1'b1;
    @(negedge clk);
    while (!ir_s && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!ir_s) check_eq("push_timeout", 128'(ir_s), 128'd1);
    @(posedge clk);
    #1;
    iv_s = 1'b0;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  localparam logic [127:0] V_IN   = 128'h3052411e_e55db4b8_f198bfe0_ae1127d4;
  localparam logic [127:0] V_MIX  = 128'h4c260628_7ad3f848_9a19cbe0_e5816604;
  localparam logic [127:0] V_LAST = 128'he598271e_f11141b8_ae52b4e0_305dbfd4;

  int d0;

  initial begin
    repeat (2) @(posedge clk);
    #2;
    check_eq("rst_out_valid", 128'(ov_s), 128'd0);
    check_eq("rst_out_state", os_s, 128'd0);
    check_eq("rst_out_last", 128'(ol_s), 128'd0);
    check_eq("rst_in_ready_s", 128'(ir_s), 128'd0);
    check_eq("rst_in_ready_r", 128'(ir_r), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("release_ready_s", 128'(ir_s), 128'd1);
    check_eq("release_ready_r", 128'(ir_r), 128'd1);

    or_s = 1'b1;
    or_r = 1'b1;
    push_s(V_IN, 1'b0);
    check_eq("vec_mix_valid", 128'(ov_s), 128'd1);
    check_eq("vec_mix_state", os_s, V_MIX);
    check_eq("vec_mix_last", 128'(ol_s), 128'd0);
    push_s(V_IN, 1'b1);
    check_eq("vec_last_state", os_s, V_LAST);
    check_eq("vec_last_last", 128'(ol_s), 128'd1);
    // db,13,53,45 placed so that ShiftRows lands them in column 0.
    push_s(128'h45000000_00530000_00001300_000000db, 1'b0);
    check_eq("col_mix_state", os_s, 128'h00000000_00000000_00000000_bca14d8e);
    @(posedge clk);
    #1;

    // Backpressure on the skid variant.
    or_s = 1'b0;
    d0 = del_s;
    push_s(rnd128(), 1'b0);
    check_eq("bp_ready_one", 128'(ir_s), 128'd1);
    push_s(rnd128(), 1'b1);
    check_eq("bp_ready_two", 128'(ir_s), 128'd0);
    in_state = rnd128();
    in_last  = 1'b0;
    iv_s     = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_eq("bp_hold_ready", 128'(ir_s), 128'd0);
    end
    @(posedge clk);
    #1;
    or_s = 1'b1;
    push_s(in_state, in_last);
    repeat (4) @(posedge clk);
    #1;
    check_eq("bp_drained", 128'(q_s.size()), 128'd0);
    check_eq("bp_delivered", 128'(del_s - d0), 128'd3);

    // Back-to-back throughput on both variants.
    d0 = del_r;
    for (int i = 0; i < 16; i++) begin
      in_state = rnd128();
      in_last  = 1'($urandom_range(0, 1));
      iv_s = 1'b1;
      iv_r = 1'b1;
      @(negedge clk);
      check_eq("tp_ready_s", 128'(ir_s), 128'd1);
      check_eq("tp_ready_r", 128'(ir_r), 128'd1);
      if (i > 0) begin
        check_eq("tp_valid_s", 128'(ov_s), 128'd1);
        check_eq("tp_valid_r", 128'(ov_r), 128'd1);
      end
      @(posedge clk);
      #1;
    end
    iv_s = 1'b0;
    iv_r = 1'b0;
    @(posedge clk);
    #1;
    check_eq("tp_count_r", 128'(del_r - d0), 128'd16);
    check_eq("tp_empty_s", 128'(q_s.size()), 128'd0);
    check_eq("tp_empty_r", 128'(q_r.size()), 128'd0);

    // Asynchronous reset with two beats held in the skid buffer.
    or_s = 1'b0;
    push_s(rnd128(), 1'b0);
    push_s(rnd128(), 1'b1);
    #2;
    rst_n = 1'b0;
    q_s.delete();
    q_r.delete();
    #1;
    check_eq("arst_out_valid", 128'(ov_s), 128'd0);
    check_eq("arst_in_ready", 128'(ir_s), 128'd0);
    check_eq("arst_out_state", os_s, 128'd0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("arst_release_ready", 128'(ir_s), 128'd1);
    check_eq("arst_no_stale", 128'(ov_s), 128'd0);
    or_s = 1'b1;
    d0 = del_s;
    push_s(rnd128(), 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("arst_next_beat", 128'(del_s - d0), 128'd1);
    check_eq("arst_empty", 128'(q_s.size()), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/shift_mix_stage.md
Name: shift_mix_stage

Overview:
- Registered AES encryption round stage directly downstream of the SubBytes block.
- Consumes the 128-bit substituted state and applies ShiftRows, then MixColumns; MixColumns is skipped on the final round.
- Provides a valid/ready handshake so the encryption datapath can be pipelined and stalled. Output feeds the AddRoundKey stage.

Parameters:
- SKID, 1, 1 = two-entry skid buffer with registered in_ready and full throughput; 0 = single output register with in_ready = !out_valid | out_ready.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_state  input  128  SubBytes output; byte i = in_state[8i+7:8i]; byte i is row i%4, column i/4 (column-major, byte 0 in the LSBs)
- in_last  input  1  final round: bypass MixColumns
- in_valid  input  1  in_state/in_last valid
- in_ready  output  1  stage can accept a beat
- out_state  output  128  result, same byte ordering as in_state
- out_last  output  1  in_last carried with the beat
- out_valid  output  1  out_state/out_last valid
- out_ready  input  1  downstream accepts

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low (rst_n). While rst_n=0: out_valid=0, out_state=0, out_last=0, in_ready=0, skid entry empty. On the first clk edge after release, in_ready=1.
- Beat transfer: a beat is accepted when in_valid & in_ready at a clk edge. It is delivered when out_valid & out_ready at a clk edge.
- ShiftRows: out byte (r,c) = in byte (r,(c+r) mod 4).
- MixColumns, per column [a0..a3] (rows 0..3), with xt(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1B : 8'h00):
  - b0 = xt(a0)^xt(a1)^a1^a2^a3
  - b1 = a0^xt(a1)^xt(a2)^a2^a3
  - b2 = a0^a1^xt(a2)^xt(a3)^a3
  - b3 = xt(a0)^a0^a1^a2^xt(a3)
  - All arithmetic is 8-bit GF(2^8); no carries.
- in_last=1: output = ShiftRows only.
- Latency: a beat accepted at edge N is presented with out_valid=1 after edge N. Throughput is 1 beat/cycle when out_ready is held high.
- Ordering: the beat order is preserved; out_last always travels with its own beat.
- Once out_valid=1, out_state/out_last are held stable until the beat is delivered.
- SKID=1 states:
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: out register full, skid empty, in_ready=1.
  - TWO: both full, in_ready=0.
- SKID=1 transitions:
  - EMPTY + accept -> ONE.
  - ONE + accept + no deliver -> TWO (the new beat goes to skid).
  - ONE + accept + deliver -> ONE (the new beat goes to the out register).
  - ONE + deliver only -> EMPTY.
  - TWO + deliver -> ONE (skid moves to the out register; no accept is possible, since in_ready=0).
  - in_ready is driven from a register (= state != TWO) and has no combinational path from out_ready.
- SKID=0: in_ready = !out_valid | out_ready (combinational).
  - Simultaneous deliver + accept loads the new beat and out_valid stays 1.
  - Deliver without accept clears out_valid.
- in_valid while in_ready=0: ignored; the source must hold the beat.
- in_valid=0: no state change except delivery.
- Reset asserted mid-operation: all beats in flight are discarded immediately; no partial outputs.

Test Plan:
- MixColumns round vector (in_last=0): in_state=128'h3052411e_e55db4b8_f198bfe0_ae1127d4 (FIPS-197 round 1 after SubBytes), out_ready=1 -> one cycle later out_valid=1, out_state=128'h4c260628_7ad3f848_9a19cbe0_e5816604, out_last=0.
- Final-round bypass: same in_state with in_last=1 -> out_state=128'he598271e_f11141b8_ae52b4e0_305dbfd4, out_last=1.
- Single-column MixColumns check: column 0 = db,13,53,45 and other bytes 0, in_last=0 -> output column 0 = 8e,4d,a1,bc; all other columns 0.
- Backpressure (SKID=1): out_ready=0 and stream 3 beats with in_valid=1:
  - Beats 1 and 2 accepted; in_ready=0 from the next cycle; beat 3 held at the source.
  - Raise out_ready -> beats delivered in order 1,2,3 with no loss or duplication; out_state stable while stalled.
- Throughput: 16 back-to-back beats with random in_last and out_ready=1 -> 16 outputs on consecutive cycles matching the reference model, for both SKID=1 and SKID=0.
- Reset: hold 2 beats in the buffer, pulse rst_n low asynchronously between edges -> out_valid=0 and in_ready=0 immediately; after release no stale beat appears and the next beat processes correctly.
